// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data access controller behind tlb_top.
// Screens alignment/TLB faults, runs one req/ack bus cycle, formats load data.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic        mem_signed,
    input  logic [31:0] mem_vaddr,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] tlb_paddr,
    input  logic        tlb_miss,
    input  logic        tlb_valid,
    input  logic        tlb_dirty,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        exc,
    output logic [4:0]  exc_code,
    output logic        tlb_refill,
    output logic [31:0] badvaddr
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [31:0] LAST = TIMEOUT_CYCLES - 1;

    state_t      state;
    logic [31:0] cnt;
    logic [1:0]  lat_size;
    logic        lat_signed;
    logic [1:0]  lat_off;
    logic [31:0] lat_vaddr;

    logic        mapped;
    logic [31:0] paddr;
    logic [1:0]  off;
    logic        misaligned;
    logic        fault;
    logic [4:0]  fault_code;
    logic        fault_refill;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;

    // kseg0/kseg1 bypass the TLB entirely
    assign mapped     = mem_vaddr[31:30] != 2'b10;
    assign paddr      = mapped ? tlb_paddr : {3'b000, mem_vaddr[28:0]};
    assign off        = mem_vaddr[1:0];
    assign misaligned = (mem_size == 2'b01 && off[0]) ||
                        (mem_size[1] && off != 2'b00);
    assign stall      = (state == IDLE && mem_en) || state == REQ;

    always_comb begin
        fault        = 1'b1;
        fault_code   = 5'd0;
        fault_refill = 1'b0;
        if (misaligned) begin
            fault_code = mem_we ? 5'd5 : 5'd4;
        end else if (mapped && tlb_miss) begin
            fault_code   = mem_we ? 5'd3 : 5'd2;
            fault_refill = 1'b1;
        end else if (mapped && !tlb_valid) begin
            fault_code = mem_we ? 5'd3 : 5'd2;
        end else if (mapped && mem_we && !tlb_dirty) begin
            fault_code = 5'd1;
        end else begin
            fault = 1'b0;
        end
    end

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = mem_wdata;
        case (mem_size)
            2'b00: begin
                be_c    = 4'b0001 << off;
                wdata_c = {4{mem_wdata[7:0]}};
            end
            2'b01: begin
                be_c    = off[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{mem_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    function automatic logic [31:0] fmt_load(
        input logic [1:0]  sz,
        input logic        sgn,
        input logic [1:0]  o,
        input logic [31:0] d
    );
        logic [31:0] sh;
        sh = d >> {o, 3'b000};
        case (sz)
            2'b00:   fmt_load = {{24{sgn & sh[7]}}, sh[7:0]};
            2'b01:   fmt_load = {{16{sgn & sh[15]}}, sh[15:0]};
            default: fmt_load = d;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_size   <= '0;
            lat_signed <= 1'b0;
            lat_off    <= '0;
            lat_vaddr  <= '0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_be     <= '0;
            bus_wdata  <= '0;
            done       <= 1'b0;
            rdata      <= '0;
            exc        <= 1'b0;
            exc_code   <= '0;
            tlb_refill <= 1'b0;
            badvaddr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_en && fault) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        exc        <= 1'b1;
                        exc_code   <= fault_code;
                        tlb_refill <= fault_refill;
                        badvaddr   <= mem_vaddr;
                        rdata      <= '0;
                    end else if (mem_en) begin
                        state      <= REQ;
                        lat_size   <= mem_size;
                        lat_signed <= mem_signed;
                        lat_off    <= off;
                        lat_vaddr  <= mem_vaddr;
                        bus_req    <= 1'b1;
                        bus_we     <= mem_we;
                        bus_addr   <= paddr & 32'hFFFF_FFFC;
                        bus_be     <= be_c;
                        bus_wdata  <= wdata_c;
                    end
                end
                REQ: begin
                    // an ack always beats a coincident timeout
                    if (bus_ack || cnt == LAST) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        cnt       <= '0;
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_addr  <= '0;
                        bus_be    <= '0;
                        bus_wdata <= '0;
                        if (bus_ack) begin
                            rdata <= bus_we ? 32'd0 :
                                     fmt_load(lat_size, lat_signed,
                                              lat_off, bus_rdata);
                        end else begin
                            exc      <= 1'b1;
                            exc_code <= 5'd7;
                            badvaddr <= lat_vaddr;
                            rdata    <= '0;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    done       <= 1'b0;
                    rdata      <= '0;
                    exc        <= 1'b0;
                    exc_code   <= '0;
                    tlb_refill <= 1'b0;
                    badvaddr   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed vectors for mem_access_ctrl (TIMEOUT_CYCLES=4).
// Each access runs to its done pulse; captured outputs are checked against hand values.
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en, mem_we, mem_signed;
    logic [1:0]  mem_size;
    logic [31:0] mem_vaddr, mem_wdata, tlb_paddr;
    logic        tlb_miss, tlb_valid, tlb_dirty;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        stall, done, exc, tlb_refill;
    logic [31:0] rdata, badvaddr;
    logic [4:0]  exc_code;

    mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size),
        .mem_signed(mem_signed), .mem_vaddr(mem_vaddr),
        .mem_wdata(mem_wdata), .tlb_paddr(tlb_paddr),
        .tlb_miss(tlb_miss), .tlb_valid(tlb_valid),
        .tlb_dirty(tlb_dirty),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .stall(stall), .done(done), .rdata(rdata), .exc(exc),
        .exc_code(exc_code), .tlb_refill(tlb_refill),
        .badvaddr(badvaddr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    int          nreq, cyc_done;
    logic [7:0]  stall_v;
    logic [31:0] s_addr, s_wd, s_rdata, s_bad;
    logic [3:0]  s_be;
    logic        s_we, s_exc, s_ref;
    logic [4:0]  s_code;

    // Starts just after a rising edge with the DUT idle; ack_at=0 never acks.
    task automatic access(input logic we, input logic [1:0] sz,
                          input logic sgn, input logic [31:0] va,
                          input logic [31:0] wd, input logic [31:0] pa,
                          input logic miss, input logic vld,
                          input logic dty, input int ack_at,
                          input logic [31:0] rd);
        nreq = 0; cyc_done = 0; stall_v = '0;
        s_addr = '0; s_wd = '0; s_be = '0; s_we = 1'b0;
        s_rdata = '0; s_bad = '0; s_exc = 1'b0; s_ref = 1'b0; s_code = '0;
        mem_en = 1'b1; mem_we = we; mem_size = sz; mem_signed = sgn;
        mem_vaddr = va; mem_wdata = wd; tlb_paddr = pa;
        tlb_miss = miss; tlb_valid = vld; tlb_dirty = dty;
        for (int c = 1; c <= 20 && cyc_done == 0; c++) begin
            #1;
            if (c <= 8) stall_v[c-1] = stall;
            if (bus_req) begin
                nreq++;
                if (nreq == 1) begin
                    s_addr = bus_addr; s_be = bus_be;
                    s_wd = bus_wdata; s_we = bus_we;
                end
            end
            if (done) begin
                cyc_done = c; s_rdata = rdata; s_exc = exc;
                s_code = exc_code; s_ref = tlb_refill; s_bad = badvaddr;
            end
            bus_ack = bus_req && nreq == ack_at;
            bus_rdata = rd;
            @(posedge clk); #1;
            bus_ack = 1'b0;
        end
        mem_en = 1'b0;
        #1 check("done_pulse", {31'd0, done}, 32'd0);
    endtask

    logic [31:0] ft_pa [3]   = '{32'h0012_3000, 32'h0012_3000, 32'h0012_3000};
    logic        ft_miss [3] = '{1'b1, 1'b0, 1'b0};
    logic        ft_vld [3]  = '{1'b1, 1'b0, 1'b1};
    logic [4:0]  ft_code [3] = '{5'd3, 5'd3, 5'd1};
    logic        ft_ref [3]  = '{1'b1, 1'b0, 1'b0};

    initial begin
        rst = 1'b1; mem_en = 1'b0; mem_we = 1'b0; mem_size = 2'b00;
        mem_signed = 1'b0; mem_vaddr = '0; mem_wdata = '0; tlb_paddr = '0;
        tlb_miss = 1'b0; tlb_valid = 1'b0; tlb_dirty = 1'b0;
        bus_ack = 1'b0; bus_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_req", {31'd0, bus_req}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_exc", {31'd0, exc}, 32'd0);
        check("rst_be", {28'd0, bus_be}, 32'd0);

        access(1'b0, 2'b10, 1'b0, 32'h8000_1004, 32'd0, 32'hFFFF_FFFF,
               1'b1, 1'b0, 1'b0, 1, 32'hDEAD_BEEF);
        check("wl_cyc", cyc_done, 3);
        check("wl_addr", s_addr, 32'h0000_1004);
        check("wl_be", {28'd0, s_be}, 32'hF);
        check("wl_we", {31'd0, s_we}, 32'd0);
        check("wl_rdata", s_rdata, 32'hDEAD_BEEF);
        check("wl_exc", {31'd0, s_exc}, 32'd0);
        check("wl_stall", {29'd0, stall_v[2:0]}, 32'b011);
        check("wl_nreq", nreq, 1);

        access(1'b0, 2'b00, 1'b1, 32'h0040_0003, 32'd0, 32'h0012_3003,
               1'b0, 1'b1, 1'b0, 1, 32'h80FF_0000);
        check("sb_addr", s_addr, 32'h0012_3000);
        check("sb_be", {28'd0, s_be}, 32'h8);
        check("sb_rdata", s_rdata, 32'hFFFF_FF80);
        access(1'b0, 2'b00, 1'b0, 32'h0040_0003, 32'd0, 32'h0012_3003,
               1'b0, 1'b1, 1'b0, 1, 32'h80FF_0000);
        check("ub_rdata", s_rdata, 32'h0000_0080);

        access(1'b0, 2'b01, 1'b1, 32'h8000_0102, 32'd0, 32'd0,
               1'b0, 1'b0, 1'b0, 1, 32'h8001_1234);
        check("sh_be", {28'd0, s_be}, 32'hC);
        check("sh_addr", s_addr, 32'h0000_0100);
        check("sh_rdata", s_rdata, 32'hFFFF_8001);

        access(1'b1, 2'b01, 1'b0, 32'h0040_0001, 32'h1234, 32'h0012_3001,
               1'b0, 1'b1, 1'b1, 1, 32'd0);
        check("ades_cyc", cyc_done, 2);
        check("ades_exc", {31'd0, s_exc}, 32'd1);
        check("ades_code", {27'd0, s_code}, 32'd5);
        check("ades_bad", s_bad, 32'h0040_0001);
        check("ades_nreq", nreq, 0);

        access(1'b0, 2'b10, 1'b0, 32'h8000_0002, 32'd0, 32'd0,
               1'b0, 1'b0, 1'b0, 1, 32'd0);
        check("adel_code", {27'd0, s_code}, 32'd4);
        check("adel_nreq", nreq, 0);

        for (int i = 0; i < 3; i++) begin
            access(1'b1, 2'b10, 1'b0, 32'h0040_0000, 32'h55, ft_pa[i],
                   ft_miss[i], ft_vld[i], 1'b0, 1, 32'd0);
            check($sformatf("tlbf%0d_code", i), {27'd0, s_code},
                  {27'd0, ft_code[i]});
            check($sformatf("tlbf%0d_ref", i), {31'd0, s_ref},
                  {31'd0, ft_ref[i]});
            check($sformatf("tlbf%0d_nreq", i), nreq, 0);
        end

        access(1'b1, 2'b00, 1'b0, 32'h8000_0002, 32'h1234_56A5, 32'd0,
               1'b0, 1'b0, 1'b0, 1, 32'hFFFF_FFFF);
        check("stb_be", {28'd0, s_be}, 32'h4);
        check("stb_wd", s_wd, 32'hA5A5_A5A5);
        check("stb_we", {31'd0, s_we}, 32'd1);
        check("stb_rdata", s_rdata, 32'd0);
        check("stb_exc", {31'd0, s_exc}, 32'd0);

        access(1'b1, 2'b01, 1'b0, 32'h0040_0002, 32'hAAAA_5678,
               32'h0012_3002, 1'b0, 1'b1, 1'b1, 1, 32'd0);
        check("sth_be", {28'd0, s_be}, 32'hC);
        check("sth_wd", s_wd, 32'h5678_5678);
        check("sth_addr", s_addr, 32'h0012_3000);

        access(1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'd0, 32'd0,
               1'b0, 1'b0, 1'b0, 0, 32'd0);
        check("to_nreq", nreq, 4);
        check("to_cyc", cyc_done, 6);
        check("to_code", {27'd0, s_code}, 32'd7);
        check("to_bad", s_bad, 32'h8000_0010);

        access(1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'd0, 32'd0,
               1'b0, 1'b0, 1'b0, 4, 32'h1357_2468);
        check("ack4_nreq", nreq, 4);
        check("ack4_exc", {31'd0, s_exc}, 32'd0);
        check("ack4_rdata", s_rdata, 32'h1357_2468);

        mem_en = 1'b1; mem_we = 1'b0; mem_size = 2'b10;
        mem_vaddr = 32'h8000_0020;
        @(posedge clk); #1;
        check("mr_req", {31'd0, bus_req}, 32'd1);
        rst = 1'b1; mem_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("mr_req0", {31'd0, bus_req}, 32'd0);
        check("mr_stall", {31'd0, stall}, 32'd0);
        check("mr_done", {31'd0, done}, 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        check("mr_ackign", {31'd0, done}, 32'd0);
        access(1'b0, 2'b10, 1'b0, 32'h8000_0030, 32'd0, 32'd0,
               1'b0, 1'b0, 1'b0, 1, 32'h0BAD_F00D);
        check("mr_cyc", cyc_done, 3);
        check("mr_rdata", s_rdata, 32'h0BAD_F00D);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
